// File: rtl/reg_file_mp.sv
// Multi-port register file with write-port priority, optional write-to-read
// forwarding, an optional hardwired zero register and a per-register pending bitmap.
module reg_file_mp #(
    parameter int DW       = 32,
    parameter int DEPTH    = 32,
    parameter int NW       = 5,
    parameter int NR       = 11,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NW-1:0]    wr_en,
    input  logic [NW*AW-1:0] wr_addr,
    input  logic [NW*DW-1:0] wr_data,
    input  logic [NR*AW-1:0] rd_addr,
    output logic [NR*DW-1:0] rd_data,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    output logic [DEPTH-1:0] busy,
    output logic [NR-1:0]    rd_busy
);

    logic [DW-1:0]    regs   [DEPTH];
    logic [DW-1:0]    wr_val [DEPTH];
    logic [DEPTH-1:0] wr_hit;
    logic [DEPTH-1:0] rsv_hit;

    // An address is live if it exists and is not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    always_comb begin : write_resolve
        // NOTE: every combinational output gets a default first, so no path infers a latch.
        wr_hit  = '0;
        rsv_hit = '0;
        for (int a = 0; a < DEPTH; a++) wr_val[a] = '0;
        // Ascending scan: a later (higher-index) port overwrites an earlier one.
        for (int i = 0; i < NW; i++) begin
            if (wr_en[i] && addr_ok(wr_addr[i*AW +: AW])) begin
                wr_hit[wr_addr[i*AW +: AW]] = 1'b1;
                wr_val[wr_addr[i*AW +: AW]] = wr_data[i*DW +: DW];
            end
        end
        if (rsv_en && addr_ok(rsv_addr)) rsv_hit[rsv_addr] = 1'b1;
    end

    always_comb begin : read_mux
        rd_data = '0;
        rd_busy = '0;
        for (int j = 0; j < NR; j++) begin
            if (addr_ok(rd_addr[j*AW +: AW])) begin
                if ((BYPASS != 0) && wr_hit[rd_addr[j*AW +: AW]])
                    rd_data[j*DW +: DW] = wr_val[rd_addr[j*AW +: AW]];
                else
                    rd_data[j*DW +: DW] = regs[rd_addr[j*AW +: AW]];
                rd_busy[j] = busy[rd_addr[j*AW +: AW]];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the storage array is reset deliberately: software relies on all registers reading zero after reset.
            for (int a = 0; a < DEPTH; a++) regs[a] <= '0;
            busy <= '0;
        end else begin
            for (int a = 0; a < DEPTH; a++) begin
                if (wr_hit[a]) regs[a] <= wr_val[a];
                // A reserve wins over a same-cycle write that would otherwise retire the pending bit.
                busy[a] <= rsv_hit[a] | (busy[a] & ~wr_hit[a]);
            end
        end
    end

endmodule
